sseg_to_hex_capture: RTL and testbench



---
 rtl/sseg_to_hex_capture_if.sv | 22 ++
 rtl/sseg_to_hex_capture.sv | 212 +++++++++++++++++++++
 tb/tb_sseg_to_hex_capture.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_to_hex_capture_if.sv
// Display-bus bundle for sseg_to_hex_capture: scanned anode/cathode pins in, recovered digits out.
// With SSEG_DP_EN defined the decimal point (dp in, dp_out back) is carried as well.
interface sseg_to_hex_capture_if #(
    parameter int DIGITS = 4
) ();
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_valid;
    logic                update;
    logic                err;
`ifdef SSEG_DP_EN
    logic                dp;
    logic [DIGITS-1:0]   dp_out;

    modport master (output an, seg, dp, input value, digit_valid, update, err, dp_out);
    modport slave  (input an, seg, dp, output value, digit_valid, update, err, dp_out);
`else
    modport master (output an, seg, input value, digit_valid, update, err);
    modport slave  (input an, seg, output value, digit_valid, update, err);
`endif
endinterface

// File: rtl/sseg_to_hex_capture.sv
// Passive monitor of a multiplexed active-low 7-segment bus; recovers the hex nibble shown per digit.
// Optional decimal-point capture is enabled with the SSEG_DP_EN macro.
module sseg_to_hex_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sseg_to_hex_capture_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SSEG_DP_EN
    localparam int IN_W  = DIGITS + 8;
`else
    localparam int IN_W  = DIGITS + 7;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // {legal, nibble} for an active-low gfedcba glyph
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] d;
        case (s)
            7'h40:   d = {1'b1, 4'h0};
            7'h79:   d = {1'b1, 4'h1};
            7'h24:   d = {1'b1, 4'h2};
            7'h30:   d = {1'b1, 4'h3};
            7'h19:   d = {1'b1, 4'h4};
            7'h12:   d = {1'b1, 4'h5};
            7'h02:   d = {1'b1, 4'h6};
            7'h78:   d = {1'b1, 4'h7};
            7'h00:   d = {1'b1, 4'h8};
            7'h10:   d = {1'b1, 4'h9};
            7'h08:   d = {1'b1, 4'hA};
            7'h03:   d = {1'b1, 4'hB};
            7'h46:   d = {1'b1, 4'hC};
            7'h21:   d = {1'b1, 4'hD};
            7'h06:   d = {1'b1, 4'hE};
            7'h0E:   d = {1'b1, 4'hF};
            default: d = 5'b0_0000;
        endcase
        return d;
    endfunction

    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;
    logic [IN_W-1:0]     in_s;
    logic [IN_W-1:0]     prev_r;
    logic                chg_s;
    logic [CNT_W-1:0]    stable_cnt_r;
    state_t              state_r;
    state_t              state_s;
    logic                idle_s;
    logic [DIGITS-1:0]   prev_an_s;
    logic [6:0]          prev_seg_s;
    logic [3:0]          zeros_s;
    logic [SEL_W-1:0]    sel_s;
    logic                multi_s;
    logic                hit_s;
    logic [4:0]          dec_s;
    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   digit_valid_r;
    logic                update_r;
    logic                err_r;
`ifdef SSEG_DP_EN
    logic                dp_r;
    logic                prev_dp_s;
    logic [DIGITS-1:0]   dp_out_r;

    assign in_s      = {dp_r, an_r, seg_r};
    assign prev_dp_s = prev_r[IN_W-1];
`else
    assign in_s      = {an_r, seg_r};
`endif

    assign chg_s      = (in_s != prev_r);
    assign idle_s     = &an_r;
    // Captures act on prev_r: the snapshot that was actually stable, even if the pins move again now
    assign prev_an_s  = prev_r[DIGITS+6:7];
    assign prev_seg_s = prev_r[6:0];
    assign dec_s      = seg_decode(prev_seg_s);

    // Input stage plus one-cycle-delayed copy used for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r   <= {DIGITS{1'b1}};
            seg_r  <= 7'h7F;
            prev_r <= {IN_W{1'b1}};
`ifdef SSEG_DP_EN
            dp_r   <= 1'b1;
`endif
        end else begin
            an_r   <= bus.an;
            seg_r  <= bus.seg;
            prev_r <= in_s;
`ifdef SSEG_DP_EN
            dp_r   <= bus.dp;
`endif
        end
    end

    // Stability counter: cleared on any change, saturates at STABLE_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt_r <= {CNT_W{1'b0}};
        end else if (chg_s) begin
            stable_cnt_r <= {CNT_W{1'b0}};
        end else if (stable_cnt_r != CNT_MAX) begin
            stable_cnt_r <= stable_cnt_r + CNT_ONE;
        end else begin
            stable_cnt_r <= stable_cnt_r;
        end
    end

    // Anode analysis of the stable snapshot: number of low anodes and index of the low one
    always_comb begin
        zeros_s = 4'd0;
        sel_s   = {SEL_W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            zeros_s = zeros_s + {3'b000, ~prev_an_s[i]};
            sel_s   = prev_an_s[i] ? sel_s : SEL_W'(i);
        end
        multi_s = (zeros_s > 4'd1);
        hit_s   = (zeros_s == 4'd1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!idle_s) state_s = SETTLE;
                else         state_s = IDLE;
            end
            SETTLE: begin
                if (chg_s)                        state_s = idle_s ? IDLE : SETTLE;
                else if (stable_cnt_r == CNT_CAP) state_s = CAPTURE;
                else                              state_s = SETTLE;
            end
            // A change landing during the capture cycle must still restart settling
            CAPTURE, HOLD: begin
                if (chg_s) state_s = idle_s ? IDLE : SETTLE;
                else       state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // Capture actions: only the digit under the single low anode is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r       <= {(4*DIGITS){1'b0}};
            digit_valid_r <= {DIGITS{1'b0}};
            update_r      <= 1'b0;
            err_r         <= 1'b0;
`ifdef SSEG_DP_EN
            dp_out_r      <= {DIGITS{1'b0}};
`endif
        end else begin
            update_r <= 1'b0;
            err_r    <= 1'b0;
            if (state_r == CAPTURE) begin
                if (multi_s) begin
                    err_r <= 1'b1;
                end else if (hit_s) begin
                    update_r <= 1'b1;
`ifdef SSEG_DP_EN
                    dp_out_r[sel_s] <= ~prev_dp_s;
`endif
                    if (dec_s[4]) begin
                        value_r[{sel_s, 2'b00} +: 4] <= dec_s[3:0];
                        digit_valid_r[sel_s]         <= 1'b1;
                    end else if (prev_seg_s == SEG_BLANK) begin
                        value_r[{sel_s, 2'b00} +: 4] <= 4'h0;
                        digit_valid_r[sel_s]         <= 1'b0;
                    end else begin
                        digit_valid_r[sel_s] <= 1'b0;
                        err_r                <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.update      = update_r;
    assign bus.err         = err_r;
`ifdef SSEG_DP_EN
    assign bus.dp_out      = dp_out_r;
`endif

endmodule

// File: tb/tb_sseg_to_hex_capture.sv
// Self-checking bench for sseg_to_hex_capture: run-length reference model plus directed and random scans.
// Build with SSEG_DP_EN defined to exercise the decimal-point capture.
module tb_sseg_to_hex_capture;
    localparam int DIGITS = 4;
    localparam int STABLE = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] an_pin;
    logic [6:0] seg_pin;
    logic       dp_pin;

    sseg_to_hex_capture_if #(.DIGITS(DIGITS)) bus ();

    sseg_to_hex_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.an  = an_pin;
    assign bus.seg = seg_pin;
`ifdef SSEG_DP_EN
    assign bus.dp  = dp_pin;
`endif

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int total = 0;
    int bad   = 0;
    int upd_seen  = 0;
    int err_seen  = 0;
    int both_seen = 0;

    // reference model state
    logic [15:0] m_value;
    logic [3:0]  m_valid;
    logic        m_update;
    logic        m_err;
    logic [3:0]  m_dpo;
    logic [11:0] last_s;
    int          last_len;
    logic [11:0] h_s [3];
    int          h_l [3];
    logic [11:0] cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_value  = 16'h0000;
        m_valid  = 4'b0000;
        m_update = 1'b0;
        m_err    = 1'b0;
        m_dpo    = 4'b0000;
        last_s   = 12'hFFF;
        last_len = 1;
        for (int i = 0; i < 3; i++) begin
            h_s[i] = 12'hFFF;
            h_l[i] = 0;
        end
    endtask

    // A sample {dp,an,seg} held for STABLE+1 consecutive clock samples is acted on two edges later.
    task automatic model_capture(input logic [11:0] g);
        logic [3:0] a;
        logic [6:0] s;
        int zeros;
        int idx;
        int nib;
        a = g[10:7];
        s = g[6:0];
        zeros = 0;
        idx = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 0) return;
        if (zeros > 1) begin
            m_err = 1'b1;
            return;
        end
        m_update = 1'b1;
        m_dpo[idx] = ~g[11];
        nib = -1;
        for (int n = 0; n < 16; n++) if (glyph[n] == s) nib = n;
        if (nib >= 0) begin
            m_value[idx*4 +: 4] = 4'(nib);
            m_valid[idx] = 1'b1;
        end else if (s == 7'h7F) begin
            m_value[idx*4 +: 4] = 4'h0;
            m_valid[idx] = 1'b0;
        end else begin
            m_valid[idx] = 1'b0;
            m_err = 1'b1;
        end
    endtask

    // reference model, advanced on every sampling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cur = {dp_pin, an_pin, seg_pin};
                if (cur == last_s) begin
                    if (last_len < 100000) last_len++;
                end else begin
                    last_len = 1;
                end
                last_s = cur;
                h_s[0] = h_s[1]; h_s[1] = h_s[2]; h_s[2] = cur;
                h_l[0] = h_l[1]; h_l[1] = h_l[2]; h_l[2] = last_len;
                m_update = 1'b0;
                m_err    = 1'b0;
                if (h_l[0] == STABLE + 1) model_capture(h_s[0]);
            end
        end
    end

    // every-cycle compare against the model, plus pulse tallies for the directed checks
    initial begin
        forever begin
            @(negedge clk);
            chk("value",       32'(bus.value),       32'(m_value));
            chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
            chk("update",      32'(bus.update),      32'(m_update));
            chk("err",         32'(bus.err),         32'(m_err));
`ifdef SSEG_DP_EN
            chk("dp_out",      32'(bus.dp_out),      32'(m_dpo));
`endif
            if (bus.update) upd_seen++;
            if (bus.err) err_seen++;
            if (bus.update && bus.err) both_seen++;
        end
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an_pin  = a;
        seg_pin = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int n_lat;
    int u0;
    int e0;
    int b0;
    int r;
    int x;
    int y;
    logic [3:0] ra;
    logic [6:0] rs;

    initial begin
        an_pin  = 4'b1110;
        seg_pin = 7'h24;
        dp_pin  = 1'b1;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_value", 32'(bus.value), 32'h0);
        chk("rst_valid", 32'(bus.digit_valid), 32'h0);
        rst_n = 1'b1;

        // latency from the first sampling edge after release
        @(posedge clk);
        #1;
        n_lat = 0;
        while (n_lat < 20 && !bus.update) begin
            @(posedge clk);
            #1;
            n_lat++;
        end
        chk("latency", 32'(n_lat), 32'd10);
        chk("lat_digit0", 32'(bus.value[3:0]), 32'h2);
        chk("lat_valid", 32'(bus.digit_valid), 32'b0001);
        drive(4'b1110, 7'h24, 2);

        // scan 1,2,3,4
        u0 = upd_seen; e0 = err_seen;
        for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), glyph[d+1], 16);
        chk("scan_value", 32'(bus.value), 32'h4321);
        chk("scan_valid", 32'(bus.digit_valid), 32'hF);
        chk("scan_updates", 32'(upd_seen - u0), 32'd4);
        chk("scan_errs", 32'(err_seen - e0), 32'd0);

        // glitching segments never settle
        u0 = upd_seen; e0 = err_seen;
        for (int k = 0; k < 3; k++) begin
            drive(4'b1110, 7'h40, 4);
            drive(4'b1110, 7'h79, 4);
        end
        chk("glitch_updates", 32'(upd_seen - u0), 32'd0);
        chk("glitch_errs", 32'(err_seen - e0), 32'd0);
        drive(4'b1110, 7'h79, 12);
        chk("glitch_hold_upd", 32'(upd_seen - u0), 32'd1);
        chk("glitch_hold_val", 32'(bus.value[3:0]), 32'h1);

        // illegal glyph then blank on digit 1
        drive(4'b1101, 7'h78, 12);
        chk("d1_seven", 32'(bus.value[7:4]), 32'h7);
        b0 = both_seen; e0 = err_seen;
        drive(4'b1101, 7'h55, 12);
        chk("illegal_both", 32'(both_seen - b0), 32'd1);
        chk("illegal_hold", 32'(bus.value[7:4]), 32'h7);
        chk("illegal_valid", 32'(bus.digit_valid[1]), 32'd0);
        e0 = err_seen;
        drive(4'b1101, 7'h7F, 12);
        chk("blank_value", 32'(bus.value[7:4]), 32'h0);
        chk("blank_errs", 32'(err_seen - e0), 32'd0);

        // two anodes low, then all off
        u0 = upd_seen; e0 = err_seen;
        drive(4'b1100, 7'h79, 20);
        chk("multi_errs", 32'(err_seen - e0), 32'd1);
        chk("multi_updates", 32'(upd_seen - u0), 32'd0);
        chk("multi_value", 32'(bus.value), 32'h4301);
        u0 = upd_seen; e0 = err_seen;
        drive(4'b1111, 7'h79, 12);
        chk("idle_pulses", 32'((upd_seen - u0) + (err_seen - e0)), 32'd0);

        // reset while settling
        drive(4'b1011, 7'h30, 5);
        rst_n = 1'b0;
        drive(4'b1011, 7'h30, 2);
        chk("midrst_value", 32'(bus.value), 32'h0);
        chk("midrst_valid", 32'(bus.digit_valid), 32'h0);
        rst_n = 1'b1;
        drive(4'b1011, 7'h30, 12);
        chk("post_rst_value", 32'(bus.value), 32'h0300);
        chk("post_rst_valid", 32'(bus.digit_valid), 32'b0100);

`ifdef SSEG_DP_EN
        dp_pin = 1'b0;
        drive(4'b1110, 7'h0E, 12);
        chk("dp_value", 32'(bus.value[3:0]), 32'hF);
        chk("dp_on", 32'(bus.dp_out[0]), 32'd1);
        u0 = upd_seen;
        dp_pin = 1'b1;
        drive(4'b1110, 7'h0E, 12);
        chk("dp_off", 32'(bus.dp_out[0]), 32'd0);
        chk("dp_recapture", 32'(upd_seen - u0), 32'd1);
`endif

        // randomized scanning, with one reset in the middle
        for (int it = 0; it < 200; it++) begin
            if (it == 100) begin
                rst_n = 1'b0;
                drive(an_pin, seg_pin, 2);
                rst_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            x = $urandom_range(0, 3);
            y = (x + 1 + $urandom_range(0, 2)) % 4;
            if (r < 6)       ra = ~(4'b0001 << x);
            else if (r < 8)  ra = ~((4'b0001 << x) | (4'b0001 << y));
            else if (r == 8) ra = 4'b1111;
            else             ra = 4'($urandom);
            r = $urandom_range(0, 11);
            if (r < 10)       rs = glyph[$urandom_range(0, 15)];
            else if (r == 10) rs = 7'h7F;
            else              rs = 7'($urandom);
`ifdef SSEG_DP_EN
            dp_pin = 1'($urandom);
`endif
            drive(ra, rs, $urandom_range(1, 14));
        end
        drive(4'b1111, 7'h7F, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
